// File: rtl/fetch_queue.sv
// Instruction fetch queue: circular FIFO of (instr, pc) between IFU and decode.
// Optional FETCH_QUEUE_BYPASS_EN lets an empty queue forward in_* straight to out_*.
module fetch_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 2
) (
  input  logic          clk,
  input  logic          Reset,
  input  logic          in_valid,
  input  logic [31:0]   in_instr,
  input  logic [31:0]   in_pc,
  output logic          in_ready,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_instr,
  output logic [31:0]   out_pc,
  output logic [31:0]   out_pc4,
  output logic [31:0]   out_pc8,
  input  logic          flush,
  output logic [AW:0]   count
);

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } entry_t;

  localparam int unsigned CW = AW + 1;

  entry_t        mem [DEPTH];
  entry_t        head;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic          q_valid;
  logic          push;
  logic          pop;

  assign q_valid  = (cnt != '0);
  assign in_ready = (cnt != CW'(DEPTH));
  assign count    = cnt;

`ifdef FETCH_QUEUE_BYPASS_EN
  // Empty queue forwards the incoming word; if decode takes it, it is never stored.
  logic byp;
  logic byp_take;
  assign byp       = ~q_valid & in_valid & ~flush;
  assign byp_take  = byp & out_ready;
  assign out_valid = q_valid | byp;
  assign head      = byp ? entry_t'{instr: in_instr, pc: in_pc} : mem[rd_ptr];
  assign push      = in_valid & in_ready & ~flush & ~byp_take;
`else
  assign out_valid = q_valid;
  assign head      = mem[rd_ptr];
  assign push      = in_valid & in_ready & ~flush;
`endif

  assign pop       = q_valid & out_ready & ~flush;
  assign out_instr = head.instr;
  assign out_pc    = head.pc;
  assign out_pc4   = head.pc + 32'd4;
  assign out_pc8   = head.pc + 32'd8;

  // Storage needs no reset; only entries below cnt are ever observed.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= entry_t'{instr: in_instr, pc: in_pc};
    end
  end

  always_ff @(posedge clk) begin
    if (Reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue (DEPTH=4).
module tb_fetch_queue;

  logic        clk;
  logic        Reset;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_pc4;
  logic [31:0] out_pc8;
  logic        flush;
  logic [2:0]  count;

  int n_pass  = 0;
  int n_total = 0;

  fetch_queue #(.DEPTH(4), .AW(2)) dut (
    .clk       (clk),
    .Reset     (Reset),
    .in_valid  (in_valid),
    .in_instr  (in_instr),
    .in_pc     (in_pc),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_pc    (out_pc),
    .out_pc4   (out_pc4),
    .out_pc8   (out_pc8),
    .flush     (flush),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  initial begin
    Reset = 1'b1; in_valid = 1'b0; in_instr = '0; in_pc = '0;
    out_ready = 1'b0; flush = 1'b0;
    tick();
    tick();
    Reset = 1'b0;
    check("rst_count", 32'(count), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // 1: single push, one-cycle latency
    in_valid = 1'b1; in_pc = 32'h3000; in_instr = 32'h3C010001;
    tick();
    in_valid = 1'b0;
    check("t1_out_valid", 32'(out_valid), 32'd1);
    check("t1_out_pc", out_pc, 32'h3000);
    check("t1_out_pc4", out_pc4, 32'h3004);
    check("t1_out_pc8", out_pc8, 32'h3008);
    check("t1_out_instr", out_instr, 32'h3C010001);
    check("t1_count", 32'(count), 32'd1);

    // 2: fill, reject overflow, drain in order
    Reset = 1'b1; tick(); Reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_pc = 32'h3000 + 32'(4 * i); in_instr = 32'hA000_0000 + 32'(i);
      tick();
    end
    check("t2_full_count", 32'(count), 32'd4);
    check("t2_full_in_ready", 32'(in_ready), 32'd0);
    in_pc = 32'h3010; in_instr = 32'hA000_0004;
    tick();
    check("t2_overflow_count", 32'(count), 32'd4);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("t2_pop_pc", out_pc, 32'h3000 + 32'(4 * i));
      check("t2_pop_instr", out_instr, 32'hA000_0000 + 32'(i));
      tick();
      if (i == 0) begin
        check("t2_full_pushpop_count", 32'(count), 32'd3);
        in_valid = 1'b0;
      end
    end
    out_ready = 1'b0;
    check("t2_drained_count", 32'(count), 32'd0);
    check("t2_drained_valid", 32'(out_valid), 32'd0);

    // 3: streaming push+pop with pointer wrap
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_pc = 32'h4000 + 32'(4 * i); in_instr = 32'hB000_0000 + 32'(i);
`ifdef FETCH_QUEUE_BYPASS_EN
      #1;
      check("t3_byp_pc", out_pc, 32'h4000 + 32'(4 * i));
      tick();
      check("t3_byp_count", 32'(count), 32'd0);
`else
      tick();
      check("t3_count", 32'(count), 32'd1);
      check("t3_pc", out_pc, 32'h4000 + 32'(4 * i));
      check("t3_instr", out_instr, 32'hB000_0000 + 32'(i));
`endif
    end
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0;
    check("t3_end_count", 32'(count), 32'd0);

    // 4: flush with 3 entries, concurrent push/pop discarded
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_pc = 32'h5000 + 32'(4 * i); in_instr = 32'hC000_0000 + 32'(i);
      tick();
    end
    check("t4_pre_count", 32'(count), 32'd3);
    flush = 1'b1; out_ready = 1'b1; in_pc = 32'h6000; in_instr = 32'hDEAD_0000;
    #1;
    check("t4_flush_in_ready", 32'(in_ready), 32'd1);
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    check("t4_count", 32'(count), 32'd0);
    check("t4_out_valid", 32'(out_valid), 32'd0);
    check("t4_in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_pc = 32'h7000; in_instr = 32'hE000_0000;
    tick();
    in_valid = 1'b0;
    check("t4_post_pc", out_pc, 32'h7000);
    check("t4_post_count", 32'(count), 32'd1);

    // 5: Reset wins over flush and push
    in_valid = 1'b1; in_pc = 32'h7004; in_instr = 32'hE000_0001;
    tick();
    check("t5_pre_count", 32'(count), 32'd2);
    Reset = 1'b1; flush = 1'b1; in_pc = 32'h7008;
    tick();
    Reset = 1'b0; flush = 1'b0; in_valid = 1'b0;
    check("t5_count", 32'(count), 32'd0);
    check("t5_in_ready", 32'(in_ready), 32'd1);
    check("t5_out_valid", 32'(out_valid), 32'd0);

    // 6: PC+4/PC+8 wrap, then same-cycle behaviour on an empty queue
    in_valid = 1'b1; in_pc = 32'hFFFF_FFFC; in_instr = 32'hF000_0000;
    tick();
    in_valid = 1'b0;
    check("t6_pc", out_pc, 32'hFFFF_FFFC);
    check("t6_pc4", out_pc4, 32'h0000_0000);
    check("t6_pc8", out_pc8, 32'h0000_0004);
    out_ready = 1'b1;
    tick();
    check("t6_pop_count", 32'(count), 32'd0);
    in_valid = 1'b1; in_pc = 32'h8000; in_instr = 32'hF000_0001;
    #1;
`ifdef FETCH_QUEUE_BYPASS_EN
    check("t6_byp_valid", 32'(out_valid), 32'd1);
    check("t6_byp_pc", out_pc, 32'h8000);
    tick();
    check("t6_byp_count", 32'(count), 32'd0);
`else
    check("t6_nobyp_valid", 32'(out_valid), 32'd0);
    tick();
    check("t6_nobyp_count", 32'(count), 32'd1);
    check("t6_nobyp_pc", out_pc, 32'h8000);
`endif
    in_valid = 1'b0; out_ready = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction buffer between the fetch unit (IFU) and the decode stage.
- Captures each fetched instruction word with its PC into a small circular FIFO.
- Presents the head entry, with its PC, PC+4 and PC+8, to decode.
- Back-pressures fetch through in_ready (drives IFU stall_pc = ~in_ready) and discards wrong-path instructions on flush.

Parameters:
- DEPTH, 4, number of entries; power of two, minimum 2.
- AW, 2, pointer width = log2(DEPTH).

Ports:
- clk  input  1  rising-edge clock.
- Reset  input  1  synchronous, active-high reset.
- in_valid  input  1  fetch presents a valid instruction this cycle.
- in_instr  input  32  instruction word from IFU.
- in_pc  input  32  PC of in_instr.
- in_ready  output  1  queue can accept a push this cycle.
- out_valid  output  1  head entry is valid for decode.
- out_ready  input  1  decode consumes the head this cycle (decode not stalled).
- out_instr  output  32  head instruction.
- out_pc  output  32  head PC.
- out_pc4  output  32  out_pc + 4.
- out_pc8  output  32  out_pc + 8.
- flush  input  1  discard all queued entries (redirect).
- count  output  AW+1  current occupancy, 0..DEPTH.

Behaviour:
- Storage: DEPTH x 64 bits (instr, pc). Registers: wr_ptr and rd_ptr (AW bits, wrap modulo DEPTH), cnt (AW+1 bits).
- Reset (synchronous, highest priority): wr_ptr=0, rd_ptr=0, cnt=0. Hence out_valid=0, in_ready=1, count=0. Storage contents are don't-care. Reset overrides flush, push and pop in the same cycle.
- in_ready = (cnt != DEPTH). It is purely registered-state; no combinational path from out_ready.
- push = in_valid & in_ready & ~flush.
- pop = out_valid & out_ready & ~flush.
- out_valid = (cnt != 0).
- out_instr and out_pc are read combinationally from entry rd_ptr. When out_valid=0 they are don't-care, but the bench checks them only when valid.
- out_pc4 = out_pc + 4 and out_pc8 = out_pc + 8, both 32-bit with wrap-around modulo 2^32.
- Latency: an instruction pushed at edge N is visible on out_* after edge N (one-cycle latency) when the queue was empty.
- Push: write entry wr_ptr and increment wr_ptr, wrapping DEPTH-1 -> 0.
- Pop: increment rd_ptr, wrapping.
- Push and pop in the same cycle: both pointers advance and cnt is unchanged. This is legal at any occupancy 1..DEPTH-1.
- Full (cnt=DEPTH): in_ready=0, so no push, even if a pop occurs that cycle.
- Empty (cnt=0): pop is impossible because out_valid=0.
- Flush: wr_ptr=rd_ptr=cnt=0 next cycle. A same-cycle in_valid is dropped (wrong path) and a same-cycle out_ready has no effect. in_ready is unaffected by flush in the flush cycle.
- cnt update: cnt + push - pop, without flush or Reset.
- The count output equals cnt.
- Order is strictly FIFO. No entry is ever duplicated or lost except by flush or Reset.

Optional Feature:
- Macro: FETCH_QUEUE_BYPASS_EN.
- Defined: when cnt=0, in_valid=1 and flush=0, out_valid=1 and out_instr/out_pc come combinationally from in_instr/in_pc (zero latency).
  - If out_ready=1 that cycle, the instruction is consumed and not written; pointers and cnt are unchanged.
  - If out_ready=0, it is pushed normally.
- Not defined: out_valid depends only on cnt, and a one-cycle fetch-to-decode latency always applies.

Test Plan:
1. Reset, then push in_pc=0x3000/in_instr=0x3C010001 with out_ready=0 -> next cycle out_valid=1, out_pc=0x3000, out_pc4=0x3004, out_pc8=0x3008, count=1.
2. Push 4 consecutive instructions at PCs 0x3000..0x300C with out_ready=0 -> count=4, in_ready=0. A 5th in_valid is not accepted. Then out_ready=1 for 4 cycles -> PCs popped in order 0x3000,0x3004,0x3008,0x300C, and count returns to 0.
3. Continuous in_valid and out_ready=1 for 10 cycles -> count holds at 1 (without bypass). The output PC sequence increments by 4 each cycle, and pointers wrap past DEPTH-1 without loss.
4. Queue holding 3 entries; assert flush with in_valid=1 and out_ready=1 -> next cycle count=0, out_valid=0, and the flushed-cycle instruction never appears.
5. Queue holding 2 entries; assert Reset together with flush and in_valid -> next cycle count=0, in_ready=1, out_valid=0.
6. in_pc=0xFFFFFFFC -> out_pc4=0x00000000, out_pc8=0x00000004. With FETCH_QUEUE_BYPASS_EN, empty queue, in_valid=1 and out_ready=1 -> out_valid=1 the same cycle and count stays 0.
